// File: rtl/drive_pkg.sv
`default_nettype none
// ============================================================================
// Module      : drive_pkg
// Description : Shared definitions for the junction sequencer: tone direction
//               codes, sequencer state encoding, H-bridge drive patterns and
//               counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package drive_pkg;

  // Direction carried by a tone command (tdDir)
  typedef enum logic [1:0] {
    DIR_STRAIGHT = 2'b00,
    DIR_LEFT     = 2'b01,
    DIR_RIGHT    = 2'b10,
    DIR_BACK     = 2'b11
  } dir_e;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_TURN   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4,
    ST_PAUSE  = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  // H-bridge input patterns {In1,In2,In3,In4}
  localparam logic [3:0] HB_FWD     = 4'b0110;
  localparam logic [3:0] HB_PIVOT_L = 4'b1010;
  localparam logic [3:0] HB_PIVOT_R = 4'b0101;
  localparam logic [3:0] HB_STOP    = 4'b0000;

  localparam int unsigned CNT_W  = 12;
  localparam int unsigned WDOG_W = 26;

endpackage : drive_pkg
`default_nettype wire

// File: rtl/pulse_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sync_edge
// Description : Two-flop synchroniser for a raw asynchronous encoder pulse,
//               followed by a rising-edge detector. rise_o is high for one
//               cycle, two clocks after the raw edge, so a counter fed by it
//               updates on the third clock edge.
// Ports       : clk     - system clock
//               rst     - asynchronous active-high reset
//               pulse_i - raw asynchronous pulse
//               rise_o  - one-cycle rising-edge strobe
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pulse_i,
  output logic rise_o
);

  // [0],[1] synchroniser, [2] previous synchronised value for edge detect.
  // All cleared by reset so no spurious edge follows reset release.
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], pulse_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule : pulse_sync_edge
`default_nettype wire

// File: rtl/junction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : junction_sequencer
// Description : Drives the robot across a junction on a tone command: straight
//               to the junction centre (CLEAR), optional pivot (TURN), a stopped
//               settle period (SETTLE) and a one-cycle completion (DONE).
//               Collision pauses the active phase; counters are held.
// Config      : `define JSEQ_TIMEOUT_EN adds a pulse watchdog that latches a
//               FAULT state (err=1) when no pulse is counted for
//               TIMEOUT_CYCLES cycles in CLEAR/TURN. Undefined: err tied 0.
// Ports       : clk, rst               - clock, async active-high reset
//               tdEn, tdDir            - tone command valid / direction
//               shaftPulseL/R          - raw encoder pulses
//               colDetect              - collision present
//               fullPwm                - full-speed PWM waveform
//               hbEnA, hbEnB, hbIn     - H-bridge enables and inputs
//               busy, done, err        - status
// Revision    : 1.0 - initial release
// ============================================================================
module junction_sequencer
  import drive_pkg::*;
#(
  parameter int unsigned PULSES_CLEAR   = 40,
  parameter int unsigned PULSES_90      = 60,
  parameter int unsigned PULSES_180     = 120,
  parameter int unsigned SETTLE_CYCLES  = 5_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tdEn,
  input  logic [1:0] tdDir,
  input  logic       shaftPulseL,
  input  logic       shaftPulseR,
  input  logic       colDetect,
  input  logic       fullPwm,
  output logic       hbEnA,
  output logic       hbEnB,
  output logic [3:0] hbIn,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
    SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_e              state_q,  state_d;
  state_e              resume_q, resume_d;   // phase to return to after PAUSE
  dir_e                dir_q,    dir_d;
  logic [CNT_W-1:0]    count_q,  count_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;

  logic             w_rise_l, w_rise_r;
  logic             w_pulse;
  logic [CNT_W-1:0] w_target;
  logic [CNT_W-1:0] w_count_inc;

  pulse_sync_edge u_sync_l (.clk(clk), .rst(rst), .pulse_i(shaftPulseL), .rise_o(w_rise_l));
  pulse_sync_edge u_sync_r (.clk(clk), .rst(rst), .pulse_i(shaftPulseR), .rise_o(w_rise_r));

  // A LEFT pivot is measured on the right (outer) wheel; everything else on the left
  assign w_pulse  = (state_q == ST_TURN && dir_q == DIR_LEFT) ? w_rise_r : w_rise_l;
  assign w_target = (state_q == ST_CLEAR) ? CNT_W'(PULSES_CLEAR) :
                    (dir_q == DIR_BACK)   ? CNT_W'(PULSES_180)   : CNT_W'(PULSES_90);
  // Exit compares the count including this cycle's pulse, so a target of 0
  // leaves after one cycle and the completing pulse is acted on immediately.
  assign w_count_inc = count_q + {{(CNT_W-1){1'b0}}, w_pulse};

`ifdef JSEQ_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      resume_q <= ST_CLEAR;
      dir_q    <= DIR_STRAIGHT;
      count_q  <= '0;
      settle_q <= '0;
`ifdef JSEQ_TIMEOUT_EN
      wdog_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      dir_q    <= dir_d;
      count_q  <= count_d;
      settle_q <= settle_d;
`ifdef JSEQ_TIMEOUT_EN
      wdog_q   <= wdog_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    dir_d    = dir_q;
    count_d  = count_q;
    settle_d = '0;
    hbIn     = HB_STOP;
    hbEnA    = 1'b0;
    hbEnB    = 1'b0;
    busy     = (state_q != ST_IDLE);
    done     = 1'b0;
    err      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tdEn) begin
          dir_d   = dir_e'(tdDir);
          count_d = '0;
          state_d = ST_CLEAR;
        end
      end

      ST_CLEAR, ST_TURN: begin
        if (state_q == ST_CLEAR)      hbIn = HB_FWD;
        else if (dir_q == DIR_LEFT)   hbIn = HB_PIVOT_L;
        else                          hbIn = HB_PIVOT_R;
        hbEnA   = fullPwm;
        hbEnB   = fullPwm;
        count_d = w_count_inc;
        // Collision wins over phase completion; the pulse is still counted
        // and the resumed phase re-evaluates the target.
        if (colDetect) begin
          state_d  = ST_PAUSE;
          resume_d = state_q;
        end else if (w_count_inc == w_target) begin
          if (state_q == ST_TURN) begin
            state_d = ST_SETTLE;
          end else if (dir_q == DIR_STRAIGHT) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_TURN;
            count_d = '0;
          end
        end
`ifdef JSEQ_TIMEOUT_EN
        else if (!w_pulse && wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_FAULT;
        end
`endif
      end

      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_DONE;
        else                         settle_d = settle_q + 1'b1;
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      ST_PAUSE: begin
        if (!colDetect) state_d = resume_q;
      end

`ifdef JSEQ_TIMEOUT_EN
      ST_FAULT: begin
        err = 1'b1;
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

`ifdef JSEQ_TIMEOUT_EN
  // Runs only while staying in an active phase; any counted pulse, phase
  // change or other state restarts it from zero.
  always_comb begin
    wdog_d = '0;
    if ((state_q == ST_CLEAR || state_q == ST_TURN) && state_d == state_q && !w_pulse)
      wdog_d = wdog_q + 1'b1;
  end
`endif

endmodule : junction_sequencer
`default_nettype wire

// File: tb/tb_junction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_junction_sequencer
// Description : Directed self-checking bench for junction_sequencer with
//               small pulse/settle/timeout parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_junction_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tdEn = 1'b0;
  logic [1:0] tdDir = 2'b00;
  logic       shaftPulseL = 1'b0;
  logic       shaftPulseR = 1'b0;
  logic       colDetect = 1'b0;
  logic       fullPwm = 1'b1;
  logic       hbEnA, hbEnB, busy, done, err;
  logic [3:0] hbIn;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  junction_sequencer #(
    .PULSES_CLEAR  (4),
    .PULSES_90     (6),
    .PULSES_180    (12),
    .SETTLE_CYCLES (8),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tdEn       (tdEn),
    .tdDir      (tdDir),
    .shaftPulseL(shaftPulseL),
    .shaftPulseR(shaftPulseR),
    .colDetect  (colDetect),
    .fullPwm    (fullPwm),
    .hbEnA      (hbEnA),
    .hbEnB      (hbEnB),
    .hbIn       (hbIn),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Raw pulse high for two cycles; returns two edges after the raw edge,
  // i.e. one edge before the count updates.
  task automatic pulse_start(input logic right);
    if (right) shaftPulseR = 1'b1; else shaftPulseL = 1'b1;
    ticks(2);
    shaftPulseR = 1'b0;
    shaftPulseL = 1'b0;
  endtask

  task automatic pulses(input logic right, input int n);
    for (int i = 0; i < n; i++) begin
      pulse_start(right);
      ticks(2);
    end
  endtask

  task automatic start_cmd(input logic [1:0] dir);
    tdDir = dir;
    tdEn  = 1'b1;
    tick();
    tdEn  = 1'b0;
  endtask

  task automatic check_stopped(input string tag);
    check({tag, "_hbIn"}, 32'(hbIn), 32'h0);
    check({tag, "_en"},   32'({hbEnA, hbEnB}), 32'h0);
  endtask

  initial begin
    // ---------------- reset ----------------
    ticks(3);
    check_stopped("rst");
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err",  32'(err),  32'h0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'h0);

    // ---------------- STRAIGHT ----------------
    start_cmd(2'b00);
    check("s_busy", 32'(busy), 32'h1);
    check("s_hbIn", 32'(hbIn), 32'h6);
    check("s_en",   32'({hbEnA, hbEnB}), 32'h3);
    fullPwm = 1'b0; #1;
    check("s_en_pwm0", 32'({hbEnA, hbEnB}), 32'h0);
    fullPwm = 1'b1; #1;
    pulses(1'b0, 3);
    check("s_hbIn3", 32'(hbIn), 32'h6);
    pulse_start(1'b0);
    check("s_pre_done", 32'(done), 32'h0);
    check("s_hbIn_pre", 32'(hbIn), 32'h6);
    tick();
    check("s_done",      32'(done), 32'h1);
    check("s_done_busy", 32'(busy), 32'h1);
    check_stopped("s_done");
    tick();
    check("s_done_end", 32'(done), 32'h0);
    check("s_idle_busy", 32'(busy), 32'h0);

    // ---------------- LEFT ----------------
    start_cmd(2'b01);
    pulses(1'b0, 4);
    check("l_turn_hbIn", 32'(hbIn), 32'ha);
    pulses(1'b0, 2);           // left wheel ignored during a LEFT pivot
    pulses(1'b1, 5);
    check("l_turn5_hbIn", 32'(hbIn), 32'ha);
    pulse_start(1'b1);
    check("l_turn6_hbIn", 32'(hbIn), 32'ha);
    tick();
    check_stopped("l_settle");
    check("l_settle_busy", 32'(busy), 32'h1);
    ticks(7);
    check("l_settle_done0", 32'(done), 32'h0);
    check_stopped("l_settle_end");
    tick();
    check("l_done", 32'(done), 32'h1);
    tick();
    check("l_idle_busy", 32'(busy), 32'h0);

    // ---------------- BACK with collision ----------------
    start_cmd(2'b11);
    pulses(1'b0, 4);
    check("b_turn_hbIn", 32'(hbIn), 32'h5);
    pulses(1'b0, 5);
    colDetect = 1'b1;
    tick();
    check_stopped("b_pause");
    check("b_pause_busy", 32'(busy), 32'h1);
    pulses(1'b0, 2);           // not counted while paused
    ticks(49 - 8);
    check_stopped("b_pause_end");
    check("b_pause_busy2", 32'(busy), 32'h1);
    colDetect = 1'b0;
    tick();
    check("b_resume_hbIn", 32'(hbIn), 32'h5);
    check("b_resume_en",   32'({hbEnA, hbEnB}), 32'h3);
    pulses(1'b0, 6);
    check("b_turn11_hbIn", 32'(hbIn), 32'h5);
    pulse_start(1'b0);
    tick();
    check_stopped("b_settle");
    ticks(8);
    check("b_done", 32'(done), 32'h1);
    tick();
    check("b_idle_busy", 32'(busy), 32'h0);

    // ---------------- async reset mid-TURN ----------------
    start_cmd(2'b10);
    pulses(1'b0, 4);
    check("r_turn_hbIn", 32'(hbIn), 32'h5);
    pulses(1'b0, 2);
    rst = 1'b1;
    #2;
    check_stopped("r_async");
    check("r_async_busy", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    start_cmd(2'b00);
    check("r_new_hbIn", 32'(hbIn), 32'h6);
    pulses(1'b0, 3);
    check("r_new_busy3", 32'(busy), 32'h1);
    pulses(1'b0, 1);
    check("r_new_idle", 32'(busy), 32'h0);

    // ---------------- no pulses: watchdog ----------------
    start_cmd(2'b10);
    ticks(199);
    check("w_199_hbIn", 32'(hbIn), 32'h6);
    check("w_199_err",  32'(err),  32'h0);
    tick();
`ifdef JSEQ_TIMEOUT_EN
    check_stopped("w_fault");
    check("w_fault_err",  32'(err),  32'h1);
    check("w_fault_busy", 32'(busy), 32'h1);
    ticks(20);
    check("w_fault_hold", 32'(err), 32'h1);
`else
    ticks(50);
    check("w_nowd_hbIn", 32'(hbIn), 32'h6);
    check("w_nowd_err",  32'(err),  32'h0);
    check("w_nowd_busy", 32'(busy), 32'h1);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("w_rst_err",  32'(err),  32'h0);
    check("w_rst_busy", 32'(busy), 32'h0);

    // ---------------- tdEn held across DONE ----------------
    tdDir = 2'b00;
    tdEn  = 1'b1;
    tick();
    tdDir = 2'b11;             // changes while busy must be ignored
    tdEn  = 1'b0;
    pulses(1'b0, 1);
    tdEn  = 1'b1;
    pulses(1'b0, 2);
    tdEn  = 1'b0;
    check("h_busy_toggle", 32'(busy), 32'h1);
    check("h_hbIn_toggle", 32'(hbIn), 32'h6);
    tdDir = 2'b00;
    tdEn  = 1'b1;
    pulse_start(1'b0);
    tick();
    check("h_done1", 32'(done), 32'h1);
    tick();
    check("h_idle_busy", 32'(busy), 32'h0);
    tick();
    tdEn = 1'b0;
    check("h_restart_busy", 32'(busy), 32'h1);
    check("h_restart_hbIn", 32'(hbIn), 32'h6);
    pulses(1'b0, 4);
    check("h_second_idle", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_junction_sequencer
`default_nettype wire
